pixel_unpacker: RTL

Single-clock dequeue-side consumer for the 64-bit video word stream leaving the dual-clock frame-buffer FIFO. Accepts words with a valid/ready handshake, holds up to two words, and splits each word into 16-bit pixels, one per video clock-enable. Registered pixel output feeds the video output stage in the video clock domain. Counts underflows (enable with no pixel available) for debug.

---
 rtl/pixel_unpacker.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pixel_unpacker.sv
// Dequeue-side word-to-pixel splitter: double-buffers upstream words and emits one
// registered pixel per clock-enable, most-significant pixel first, counting underflows.

module pixel_unpacker #(
    parameter int unsigned WORD_WIDTH  = 64,
    parameter int unsigned PIXEL_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   io_enable,
    input  logic                   io_flush,
    input  logic                   io_deq_valid,
    output logic                   io_deq_ready,
    input  logic [WORD_WIDTH-1:0]  io_deq_bits,
    output logic                   io_pixel_valid,
    output logic [PIXEL_WIDTH-1:0] io_pixel_bits,
    output logic [15:0]            io_underflow_count
);

    localparam int unsigned RATIO = WORD_WIDTH / PIXEL_WIDTH;
    localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    logic [WORD_WIDTH-1:0]  cur_q, cur_d;
    logic                   cur_valid_q, cur_valid_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [WORD_WIDTH-1:0]  nxt_q, nxt_d;
    logic                   nxt_valid_q, nxt_valid_d;
    logic                   pix_valid_q, pix_valid_d;
    logic [PIXEL_WIDTH-1:0] pix_bits_q, pix_bits_d;
    logic [15:0]            uflow_cnt_q, uflow_cnt_d;

    logic                   deq_ready;
    logic                   accept;
    logic                   consume;
    logic                   last_consume;
    logic [PIXEL_WIDTH-1:0] cur_pixels [RATIO];

    // Index 0 maps to the most-significant slice of the word.
    always_comb begin
        for (int i = 0; i < int'(RATIO); i++) begin
            cur_pixels[i] = cur_q[(int'(RATIO) - 1 - i) * int'(PIXEL_WIDTH) +: PIXEL_WIDTH];
        end
    end

    always_comb begin
        deq_ready    = ~nxt_valid_q & ~io_flush & ~reset;
        accept       = io_deq_valid & deq_ready;
        consume      = io_enable & cur_valid_q & ~io_flush;
        last_consume = consume & (idx_q == LAST_IDX);
    end

    always_comb begin
        cur_d       = cur_q;
        cur_valid_d = cur_valid_q;
        idx_d       = idx_q;
        nxt_d       = nxt_q;
        nxt_valid_d = nxt_valid_q;
        pix_valid_d = pix_valid_q;
        pix_bits_d  = pix_bits_q;
        uflow_cnt_d = uflow_cnt_q;

        if (io_flush) begin
            cur_valid_d = 1'b0;
            nxt_valid_d = 1'b0;
            idx_d       = '0;
            pix_valid_d = 1'b0;
        end else begin
            if (io_enable) begin
                if (cur_valid_q) begin
                    pix_bits_d  = cur_pixels[idx_q];
                    pix_valid_d = 1'b1;
                    idx_d       = idx_q + IDX_W'(1);
                end else begin
                    pix_valid_d = 1'b0;
                    if (uflow_cnt_q != 16'hFFFF) begin
                        uflow_cnt_d = uflow_cnt_q + 16'd1;
                    end
                end
            end

            if (last_consume) begin
                idx_d = '0;
                if (nxt_valid_q) begin
                    cur_d       = nxt_q;
                    cur_valid_d = 1'b1;
                    nxt_d       = io_deq_bits;
                    nxt_valid_d = accept;
                end else if (accept) begin
                    cur_d       = io_deq_bits;
                    cur_valid_d = 1'b1;
                end else begin
                    cur_valid_d = 1'b0;
                end
            end else if (accept) begin
                // Never overwrite a valid word: fill whichever buffer is free.
                if (!cur_valid_q) begin
                    cur_d       = io_deq_bits;
                    cur_valid_d = 1'b1;
                    idx_d       = '0;
                end else begin
                    nxt_d       = io_deq_bits;
                    nxt_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_q       <= '0;
            cur_valid_q <= 1'b0;
            idx_q       <= '0;
            nxt_q       <= '0;
            nxt_valid_q <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_bits_q  <= '0;
            uflow_cnt_q <= '0;
        end else begin
            cur_q       <= cur_d;
            cur_valid_q <= cur_valid_d;
            idx_q       <= idx_d;
            nxt_q       <= nxt_d;
            nxt_valid_q <= nxt_valid_d;
            pix_valid_q <= pix_valid_d;
            pix_bits_q  <= pix_bits_d;
            uflow_cnt_q <= uflow_cnt_d;
        end
    end

    always_comb begin
        io_deq_ready       = deq_ready;
        io_pixel_valid     = pix_valid_q;
        io_pixel_bits      = pix_bits_q;
        io_underflow_count = uflow_cnt_q;
    end

endmodule
